// File: rtl/wired_store_buffer_pkg.sv
// Shared types for the store buffer and its forwarding merge.
// The load queue reuses sb_entry_t and the merge block.
package wired_store_buffer_pkg;

  localparam int SB_DEPTH = 4;

  typedef struct packed {
    logic [31:2] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } sb_entry_t;

  typedef struct packed {
    logic [31:2] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } sb_bus_req_t;

  function automatic sb_bus_req_t sb_to_req(input sb_entry_t e);
    sb_bus_req_t r;
    r.addr = e.addr;
    r.data = e.data;
    r.strb = e.strb;
    return r;
  endfunction

endpackage

// File: rtl/wired_store_buffer_if.sv
// LSU push/commit, bus write port and forwarding lookup of the store buffer.
// slave = store buffer side, master = LSU/bus side.
interface wired_store_buffer_if;

  logic        push_valid;
  logic        push_ready;
  logic [29:0] push_addr;
  logic [31:0] push_data;
  logic [3:0]  push_strb;
  logic        commit_valid;
  logic        flush;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic [29:0] bus_req_addr;
  logic [31:0] bus_req_data;
  logic [3:0]  bus_req_strb;
  logic        bus_resp_valid;
  logic [29:0] fwd_addr;
  logic [31:0] fwd_data;
  logic [3:0]  fwd_strb;
  logic        empty;

  modport slave (
    input  push_valid, push_addr, push_data, push_strb, commit_valid, flush,
           bus_req_ready, bus_resp_valid, fwd_addr,
    output push_ready, bus_req_valid, bus_req_addr, bus_req_data, bus_req_strb,
           fwd_data, fwd_strb, empty
  );

  modport master (
    output push_valid, push_addr, push_data, push_strb, commit_valid, flush,
           bus_req_ready, bus_resp_valid, fwd_addr,
    input  push_ready, bus_req_valid, bus_req_addr, bus_req_data, bus_req_strb,
           fwd_data, fwd_strb, empty
  );

endinterface

// File: rtl/wired_sb_fwd_merge.sv
// Youngest-wins byte merge over the occupied ring slots [head, tail)
// for one lookup address.
module wired_sb_fwd_merge
  import wired_store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int PTR_W = $clog2(DEPTH) + 1
) (
  input  sb_entry_t [DEPTH-1:0] entries,
  input  logic [PTR_W-1:0]      head,
  input  logic [PTR_W-1:0]      tail,
  input  logic [31:2]           addr,
  output logic [31:0]           data,
  output logic [3:0]            strb
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [PTR_W-1:0] occ;
  logic [PTR_W-1:0] ptr;
  sb_entry_t        ent;

  // Walk oldest to youngest so later matches overwrite earlier bytes.
  always_comb begin
    data = '0;
    strb = '0;
    occ  = tail - head;
    ptr  = head;
    ent  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ptr = head + PTR_W'(i);
      ent = entries[ptr[IDX_W-1:0]];
      if ((PTR_W'(i) < occ) && (ent.addr == addr)) begin
        for (int b = 0; b < 4; b++) begin
          if (ent.strb[b]) data[8*b +: 8] = ent.data[8*b +: 8];
        end
        strb = strb | ent.strb;
      end
    end
  end

endmodule

// File: rtl/wired_store_buffer.sv
// Circular store buffer: holds LSU stores speculatively until commit,
// drains committed stores in order to the bus, forwards bytes to loads.
module wired_store_buffer
  import wired_store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int PTR_W = $clog2(DEPTH) + 1
) (
  input logic                 clk,
  input logic                 rst_n,
  wired_store_buffer_if.slave sb
);

  // state  | meaning
  // S_IDLE | no request in flight; load head entry once committed
  // S_REQ  | bus_req_valid high, waiting for bus_req_ready
  // S_WAIT | request accepted, waiting for bus_resp_valid to pop head
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  localparam int               IDX_W   = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [PTR_W-1:0]     head, cmt, tail, cmt_next;
  logic                 full, push_ready, push_fire, commit_ok;
  logic [1:0]           state;
  sb_entry_t [DEPTH-1:0] mem;
  sb_bus_req_t          req;

  assign full       = (tail - head) == PTR_W'(DEPTH);
  assign push_ready = !full && !sb.flush;
  assign push_fire  = sb.push_valid && push_ready;
  assign commit_ok  = sb.commit_valid && (cmt != tail);
  assign cmt_next   = cmt + PTR_W'(commit_ok);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head  <= '0;
      cmt   <= '0;
      tail  <= '0;
      state <= S_IDLE;
      req   <= '0;
    end else begin
      cmt <= cmt_next;
      // Flush trims back to the commit point, keeping a same-cycle commit.
      if (sb.flush)       tail <= cmt_next;
      else if (push_fire) tail <= tail + PTR_ONE;
      case (state)
        S_IDLE: if (head != cmt) begin
          req   <= sb_to_req(mem[head[IDX_W-1:0]]);
          state <= S_REQ;
        end
        S_REQ:  if (sb.bus_req_ready) state <= S_WAIT;
        S_WAIT: if (sb.bus_resp_valid) begin
          head  <= head + PTR_ONE;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_fire) begin
      mem[tail[IDX_W-1:0]] <= '{addr: sb.push_addr, data: sb.push_data, strb: sb.push_strb};
    end
  end

  assign sb.push_ready    = push_ready;
  assign sb.bus_req_valid = (state == S_REQ);
  assign sb.bus_req_addr  = req.addr;
  assign sb.bus_req_data  = req.data;
  assign sb.bus_req_strb  = req.strb;
  assign sb.empty         = (head == tail);

  wired_sb_fwd_merge #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fwd_merge (
    .entries (mem),
    .head    (head),
    .tail    (tail),
    .addr    (sb.fwd_addr),
    .data    (sb.fwd_data),
    .strb    (sb.fwd_strb)
  );

  commit_needs_entry: assert property (@(posedge clk) disable iff (!rst_n)
    sb.commit_valid |-> (cmt != tail));

endmodule

// File: tb/tb_wired_store_buffer.sv
// Directed bench for wired_store_buffer: fill, drain stall, forwarding,
// flush, pointer wrap and reset during an outstanding write.
module tb_wired_store_buffer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  wired_store_buffer_if sb_if ();

  wired_store_buffer #(.DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sb    (sb_if)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    sb_if.push_valid     = 1'b0;
    sb_if.push_addr      = '0;
    sb_if.push_data      = '0;
    sb_if.push_strb      = '0;
    sb_if.commit_valid   = 1'b0;
    sb_if.flush          = 1'b0;
    sb_if.bus_req_ready  = 1'b0;
    sb_if.bus_resp_valid = 1'b0;
    sb_if.fwd_addr       = '0;
  endtask

  task automatic do_reset;
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic push(input logic [29:0] a, input logic [31:0] d, input logic [3:0] s);
    sb_if.push_valid = 1'b1;
    sb_if.push_addr  = a;
    sb_if.push_data  = d;
    sb_if.push_strb  = s;
    tick();
    sb_if.push_valid = 1'b0;
  endtask

  task automatic commit_one;
    sb_if.commit_valid = 1'b1;
    tick();
    sb_if.commit_valid = 1'b0;
  endtask

  task automatic wait_req(output bit seen);
    seen = 1'b0;
    for (int n = 0; n < 8; n++) begin
      if (sb_if.bus_req_valid) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic finish_req;
    sb_if.bus_req_ready = 1'b1;
    tick();
    sb_if.bus_req_ready  = 1'b0;
    sb_if.bus_resp_valid = 1'b1;
    tick();
    sb_if.bus_resp_valid = 1'b0;
  endtask

  task automatic lookup(input logic [29:0] a);
    sb_if.fwd_addr = a;
    #1;
  endtask

  task automatic test_reset;
    do_reset();
    lookup(30'h0);
    checks++; if (sb_if.push_ready !== 1'b1) begin errors++; $display("FAIL reset_push_ready: got %b expected 1", sb_if.push_ready); end
    checks++; if (sb_if.bus_req_valid !== 1'b0) begin errors++; $display("FAIL reset_bus_valid: got %b expected 0", sb_if.bus_req_valid); end
    checks++; if (sb_if.empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", sb_if.empty); end
    checks++; if (sb_if.fwd_strb !== 4'h0) begin errors++; $display("FAIL reset_fwd_strb: got %h expected 0", sb_if.fwd_strb); end
  endtask

  task automatic fill_four;
    logic [7:0] b;
    for (int i = 0; i < 4; i++) begin
      b = 8'hA0 + 8'(i);
      push(30'h10 + 30'(i), {b, b, b, b}, 4'hF);
      checks++; if (sb_if.bus_req_valid !== 1'b0) begin errors++; $display("FAIL fill_bus_valid[%0d]: got %b expected 0", i, sb_if.bus_req_valid); end
    end
  endtask

  task automatic test_fill;
    do_reset();
    fill_four();
    checks++; if (sb_if.push_ready !== 1'b0) begin errors++; $display("FAIL fill_push_ready: got %b expected 0", sb_if.push_ready); end
    checks++; if (sb_if.empty !== 1'b0) begin errors++; $display("FAIL fill_empty: got %b expected 0", sb_if.empty); end
    lookup(30'h12);
    checks++; if ({sb_if.fwd_data, sb_if.fwd_strb} !== {32'hA2A2A2A2, 4'hF}) begin errors++; $display("FAIL fill_fwd: got %h/%h expected a2a2a2a2/f", sb_if.fwd_data, sb_if.fwd_strb); end
    push(30'h77, 32'h77777777, 4'hF);
    lookup(30'h77);
    checks++; if (sb_if.fwd_strb !== 4'h0) begin errors++; $display("FAIL fill_overflow_push: got strb %h expected 0", sb_if.fwd_strb); end
    tick();
    checks++; if (sb_if.bus_req_valid !== 1'b0) begin errors++; $display("FAIL fill_no_drain: got %b expected 0", sb_if.bus_req_valid); end
  endtask

  task automatic test_drain_stall;
    bit seen;
    do_reset();
    fill_four();
    commit_one();
    wait_req(seen);
    checks++; if (!seen) begin errors++; $display("FAIL stall_req_timeout: got no request expected bus_req_valid=1"); end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if ({sb_if.bus_req_valid, sb_if.bus_req_addr, sb_if.bus_req_data, sb_if.bus_req_strb} !== {1'b1, 30'h10, 32'hA0A0A0A0, 4'hF}) begin
        errors++;
        $display("FAIL stall_stable[%0d]: got v=%b a=%h d=%h s=%h expected v=1 a=10 d=a0a0a0a0 s=f", k, sb_if.bus_req_valid, sb_if.bus_req_addr, sb_if.bus_req_data, sb_if.bus_req_strb);
      end
      tick();
    end
    checks++; if (sb_if.push_ready !== 1'b0) begin errors++; $display("FAIL stall_full: got %b expected 0", sb_if.push_ready); end
    sb_if.bus_req_ready = 1'b1;
    tick();
    sb_if.bus_req_ready = 1'b0;
    checks++; if (sb_if.bus_req_valid !== 1'b0) begin errors++; $display("FAIL stall_wait_valid: got %b expected 0", sb_if.bus_req_valid); end
    checks++; if (sb_if.push_ready !== 1'b0) begin errors++; $display("FAIL stall_wait_full: got %b expected 0", sb_if.push_ready); end
    sb_if.bus_resp_valid = 1'b1;
    tick();
    sb_if.bus_resp_valid = 1'b0;
    checks++; if (sb_if.push_ready !== 1'b1) begin errors++; $display("FAIL stall_pop_ready: got %b expected 1", sb_if.push_ready); end
    tick();
    tick();
    checks++; if (sb_if.bus_req_valid !== 1'b0) begin errors++; $display("FAIL stall_no_uncommitted_drain: got %b expected 0", sb_if.bus_req_valid); end
  endtask

  task automatic test_forward;
    bit seen;
    do_reset();
    push(30'h20, 32'h11223344, 4'hF);
    push(30'h20, 32'h0000AA00, 4'b0010);
    lookup(30'h20);
    checks++; if ({sb_if.fwd_data, sb_if.fwd_strb} !== {32'h1122AA44, 4'hF}) begin errors++; $display("FAIL fwd_merge: got %h/%h expected 1122aa44/f", sb_if.fwd_data, sb_if.fwd_strb); end
    lookup(30'h21);
    checks++; if ({sb_if.fwd_data, sb_if.fwd_strb} !== {32'h0, 4'h0}) begin errors++; $display("FAIL fwd_miss: got %h/%h expected 0/0", sb_if.fwd_data, sb_if.fwd_strb); end
    sb_if.push_valid = 1'b1;
    sb_if.push_addr  = 30'h30;
    sb_if.push_data  = 32'hCAFEF00D;
    sb_if.push_strb  = 4'b0011;
    lookup(30'h30);
    checks++; if (sb_if.fwd_strb !== 4'h0) begin errors++; $display("FAIL fwd_same_cycle_push: got %h expected 0", sb_if.fwd_strb); end
    tick();
    sb_if.push_valid = 1'b0;
    #1;
    checks++; if ({sb_if.fwd_data, sb_if.fwd_strb} !== {32'h0000F00D, 4'b0011}) begin errors++; $display("FAIL fwd_partial: got %h/%h expected 0000f00d/3", sb_if.fwd_data, sb_if.fwd_strb); end
    commit_one();
    wait_req(seen);
    lookup(30'h20);
    checks++; if (!seen || sb_if.bus_req_data !== 32'h11223344) begin errors++; $display("FAIL fwd_drain_req: got seen=%b d=%h expected 1/11223344", seen, sb_if.bus_req_data); end
    checks++; if ({sb_if.fwd_data, sb_if.fwd_strb} !== {32'h1122AA44, 4'hF}) begin errors++; $display("FAIL fwd_inflight: got %h/%h expected 1122aa44/f", sb_if.fwd_data, sb_if.fwd_strb); end
    finish_req();
    #1;
    checks++; if ({sb_if.fwd_data, sb_if.fwd_strb} !== {32'h0000AA00, 4'b0010}) begin errors++; $display("FAIL fwd_after_pop: got %h/%h expected 0000aa00/2", sb_if.fwd_data, sb_if.fwd_strb); end
  endtask

  task automatic test_flush;
    bit seen;
    do_reset();
    push(30'h40, 32'hD0D0D0D0, 4'hF);
    push(30'h41, 32'hD1D1D1D1, 4'hF);
    push(30'h42, 32'hD2D2D2D2, 4'hF);
    commit_one();
    sb_if.flush        = 1'b1;
    sb_if.commit_valid = 1'b1;
    #1;
    checks++; if (sb_if.push_ready !== 1'b0) begin errors++; $display("FAIL flush_push_ready: got %b expected 0", sb_if.push_ready); end
    tick();
    sb_if.flush        = 1'b0;
    sb_if.commit_valid = 1'b0;
    wait_req(seen);
    checks++; if (!seen || {sb_if.bus_req_addr, sb_if.bus_req_data} !== {30'h40, 32'hD0D0D0D0}) begin errors++; $display("FAIL flush_drain0: got seen=%b a=%h d=%h expected 1/40/d0d0d0d0", seen, sb_if.bus_req_addr, sb_if.bus_req_data); end
    finish_req();
    wait_req(seen);
    checks++; if (!seen || {sb_if.bus_req_addr, sb_if.bus_req_data} !== {30'h41, 32'hD1D1D1D1}) begin errors++; $display("FAIL flush_drain1: got seen=%b a=%h d=%h expected 1/41/d1d1d1d1", seen, sb_if.bus_req_addr, sb_if.bus_req_data); end
    finish_req();
    tick();
    tick();
    checks++; if (sb_if.bus_req_valid !== 1'b0) begin errors++; $display("FAIL flush_no_third: got %b expected 0", sb_if.bus_req_valid); end
    checks++; if (sb_if.empty !== 1'b1) begin errors++; $display("FAIL flush_empty: got %b expected 1", sb_if.empty); end
    lookup(30'h42);
    checks++; if (sb_if.fwd_strb !== 4'h0) begin errors++; $display("FAIL flush_discarded_fwd: got %h expected 0", sb_if.fwd_strb); end
  endtask

  task automatic test_wrap;
    bit seen;
    logic [31:0] d;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      d = 32'hC0DE0000 | 32'(i);
      checks++; if (sb_if.push_ready !== 1'b1) begin errors++; $display("FAIL wrap_ready[%0d]: got %b expected 1", i, sb_if.push_ready); end
      push(30'h50 + 30'(i), d, 4'hF);
      commit_one();
      wait_req(seen);
      checks++;
      if (!seen || {sb_if.bus_req_addr, sb_if.bus_req_data} !== {30'h50 + 30'(i), d}) begin
        errors++;
        $display("FAIL wrap_order[%0d]: got seen=%b a=%h d=%h expected 1/%h/%h", i, seen, sb_if.bus_req_addr, sb_if.bus_req_data, 30'h50 + 30'(i), d);
      end
      finish_req();
    end
    checks++; if (sb_if.empty !== 1'b1) begin errors++; $display("FAIL wrap_empty: got %b expected 1", sb_if.empty); end
    checks++; if (sb_if.push_ready !== 1'b1) begin errors++; $display("FAIL wrap_final_ready: got %b expected 1", sb_if.push_ready); end
  endtask

  task automatic test_reset_in_wait;
    bit seen;
    do_reset();
    push(30'h60, 32'h60606060, 4'hF);
    commit_one();
    wait_req(seen);
    sb_if.bus_req_ready = 1'b1;
    tick();
    sb_if.bus_req_ready = 1'b0;
    checks++; if (!seen || sb_if.bus_req_valid !== 1'b0) begin errors++; $display("FAIL rstw_in_wait: got seen=%b v=%b expected 1/0", seen, sb_if.bus_req_valid); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    checks++; if ({sb_if.bus_req_valid, sb_if.empty, sb_if.push_ready} !== 3'b011) begin errors++; $display("FAIL rstw_after_reset: got v/e/r=%b%b%b expected 011", sb_if.bus_req_valid, sb_if.empty, sb_if.push_ready); end
    sb_if.bus_resp_valid = 1'b1;
    tick();
    sb_if.bus_resp_valid = 1'b0;
    tick();
    checks++; if ({sb_if.bus_req_valid, sb_if.empty} !== 2'b01) begin errors++; $display("FAIL rstw_late_resp: got v/e=%b%b expected 01", sb_if.bus_req_valid, sb_if.empty); end
    push(30'h61, 32'h61616161, 4'hF);
    commit_one();
    wait_req(seen);
    checks++; if (!seen || {sb_if.bus_req_addr, sb_if.bus_req_data} !== {30'h61, 32'h61616161}) begin errors++; $display("FAIL rstw_next_store: got seen=%b a=%h d=%h expected 1/61/61616161", seen, sb_if.bus_req_addr, sb_if.bus_req_data); end
    finish_req();
    checks++; if (sb_if.empty !== 1'b1) begin errors++; $display("FAIL rstw_final_empty: got %b expected 1", sb_if.empty); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_fill();
    test_drain_stall();
    test_forward();
    test_flush();
    test_wrap();
    test_reset_in_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wired_store_buffer.md
Name: wired_store_buffer

Overview:
- Circular store buffer directly downstream of wired_lsu.
- Accepts store entries as the LSU resolves them (address translated, data aligned) and holds them speculatively until commit retires them.
- Drains committed stores in order to the bus/dcache write port.
- Supplies byte-granular store-to-load forwarding back to the LSU load path.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- PTR_W, $clog2(DEPTH)+1, pointer width including the wrap bit.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- push_valid_i  in  1  LSU offers a store entry
- push_ready_o  out  1  buffer can accept the entry this cycle
- push_addr_i  in  30  physical word address [31:2]
- push_data_i  in  32  byte-aligned store data
- push_strb_i  in  4  byte enables
- commit_valid_i  in  1  commit retires the oldest uncommitted store
- flush_i  in  1  pipeline flush; discard all uncommitted entries
- bus_req_valid_o  out  1  write request valid
- bus_req_ready_i  in  1  bus accepts the request
- bus_req_addr_o  out  30  write word address
- bus_req_data_o  out  32  write data
- bus_req_strb_o  out  4  write byte enables
- bus_resp_valid_i  in  1  write acknowledged
- fwd_addr_i  in  30  load word address for lookup
- fwd_data_o  out  32  merged forwarded bytes
- fwd_strb_o  out  4  bytes supplied by the buffer
- empty_o  out  1  no entries held; used by fence/uncached load ordering

Behaviour:
- Storage
  - Entry array {addr, data, strb}.
  - Pointers head, cmt, tail, each PTR_W bits; wrap bit distinguishes full from empty.
  - Ordering invariant: head <= cmt <= tail in ring order.
  - Committed entries are [head, cmt); speculative entries are [cmt, tail).
- Reset (rst_n=0 at a clk edge)
  - head=cmt=tail=0; FSM=IDLE.
  - Resulting outputs: push_ready_o=1, bus_req_valid_o=0, empty_o=1, fwd_strb_o=0.
  - Reset mid-drain abandons the outstanding bus write with no further handshake.
- Push
  - Fires on push_valid_i & push_ready_o: writes the entry at tail; tail+1.
  - push_ready_o = !full & !flush_i, where full = (tail-head)==DEPTH from registered pointers.
  - No same-cycle pop bypass.
- Commit
  - If cmt!=tail, cmt+1.
  - If cmt==tail, ignored; simulation assertion fires.
- Flush
  - tail <= cmt after the same-cycle commit has been applied. A committed-this-cycle store survives.
  - Flush never touches committed entries or the drain FSM.
- Drain FSM
  - IDLE: when head!=cmt, latch head entry into request registers; go to REQ.
  - REQ: bus_req_valid_o=1 with stable addr/data/strb. On bus_req_ready_i go to WAIT.
  - WAIT: on bus_resp_valid_i, head+1, go to IDLE.
  - Throughput: one store per 3 cycles minimum (IDLE→REQ→WAIT). bus_req_valid_o is registered.
  - bus_resp_valid_i outside WAIT is ignored.
- Forwarding (combinational)
  - Covers every occupied entry [head, tail), including the entry being drained until its pop.
  - Matching rule: an entry matches when addr==fwd_addr_i.
  - Per-byte merge, oldest to youngest, youngest wins.
  - fwd_strb_o = OR of matching strb; fwd_data_o bytes not covered = 0.
  - Same-cycle push is not visible to forwarding.
- empty_o = (head==tail).
- Pointer arithmetic is modulo 2^PTR_W; the index is the low log2(DEPTH) bits.

Decomposition:
- wired0_defines package gains:
  - sb_entry_t {addr[31:2], data, strb}
  - sb_bus_req_t {addr, data, strb}
  - SB_DEPTH default constant
- One sub-module: wired_sb_fwd_merge.
  - Combinational youngest-wins byte merge over the entry array, given head/tail and a lookup address.
  - Reused later by the load queue.

Test Plan:
1. Push 4 stores (addr 0x10..0x13, data 0xA0A0A0A0.., strb F), no commit → push_ready_o=0 after the 4th push, bus_req_valid_o stays 0, empty_o=0.
2. Commit 1 → bus_req_valid_o=1 with addr 0x10, data 0xA0A0A0A0 two cycles later. Hold bus_req_ready_i=0 for 5 cycles → request stable. Then ready, then resp → head advances, push_ready_o=1 next cycle.
3. Push two stores to addr 0x20: first data 0x11223344 strb F, then 0x0000AA00 strb 0010 → lookup at 0x20 returns fwd_data_o=0x1122AA44, fwd_strb_o=F. Lookup at 0x21 → strb 0.
4. Three entries, commit 1, then flush with a simultaneous commit → exactly 2 entries remain, both drained. tail==cmt afterwards; push_ready_o=0 during the flush cycle.
5. Pointer wrap: 10 push/commit/drain cycles with DEPTH=4 → data order preserved, empty_o=1 at the end, no spurious full.
6. Reset asserted in WAIT → next cycle bus_req_valid_o=0, empty_o=1; a late bus_resp_valid_i is ignored.
